// File: rtl/stream_demux.sv
// 1-to-2 valid/ready stream demultiplexer with one registered slot per output port
// and saturating per-port delivery counters.
module stream_demux #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_sel,
  output logic                 out0_valid,
  input  logic                 out0_ready,
  output logic [WIDTH-1:0]     out0_data,
  output logic                 out1_valid,
  input  logic                 out1_ready,
  output logic [WIDTH-1:0]     out1_data,
  output logic [CNT_WIDTH-1:0] cnt0,
  output logic [CNT_WIDTH-1:0] cnt1
);

  // Handshake: a word moves on any interface at a rising edge where valid and ready
  // are both high; a FULL slot keeps valid/data stable until its consumer takes it.
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_state_t;

  slot_state_t          r_state0, r_state1;
  slot_state_t          w_state0_nxt, w_state1_nxt;
  logic [WIDTH-1:0]     r_data0, r_data1;
  logic [CNT_WIDTH-1:0] r_cnt0, r_cnt1;

  logic w_drain0, w_drain1;
  logic w_accept, w_fill0, w_fill1;

  assign w_drain0 = (r_state0 == FULL) & out0_ready;
  assign w_drain1 = (r_state1 == FULL) & out1_ready;

  // Only the selected port's occupancy and ready matter, so a stalled port never
  // blocks traffic to the other one.
  assign in_ready = in_sel ? ((r_state1 == EMPTY) | out1_ready)
                           : ((r_state0 == EMPTY) | out0_ready);

  assign w_accept = in_valid & in_ready;
  assign w_fill0  = w_accept & ~in_sel;
  assign w_fill1  = w_accept &  in_sel;

  always_comb begin
    w_state0_nxt = r_state0;
    w_state1_nxt = r_state1;
    if (w_fill0)       w_state0_nxt = FULL;
    else if (w_drain0) w_state0_nxt = EMPTY;
    if (w_fill1)       w_state1_nxt = FULL;
    else if (w_drain1) w_state1_nxt = EMPTY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state0 <= EMPTY;
      r_state1 <= EMPTY;
    end else begin
      r_state0 <= w_state0_nxt;
      r_state1 <= w_state1_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data0 <= '0;
      r_data1 <= '0;
    end else begin
      if (w_fill0) r_data0 <= in_data;
      if (w_fill1) r_data1 <= in_data;
    end
  end

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_drain0 && (r_cnt0 != {CNT_WIDTH{1'b1}})) r_cnt0 <= r_cnt0 + 1'b1;
      if (w_drain1 && (r_cnt1 != {CNT_WIDTH{1'b1}})) r_cnt1 <= r_cnt1 + 1'b1;
    end
  end

  assign out0_valid = (r_state0 == FULL);
  assign out1_valid = (r_state1 == FULL);
  assign out0_data  = r_data0;
  assign out1_data  = r_data1;
  assign cnt0       = r_cnt0;
  assign cnt1       = r_cnt1;

endmodule

// File: tb/tb_stream_demux.sv
// Directed bench for stream_demux: default-width instance for routing/backpressure/
// throughput, plus a CNT_WIDTH=4 instance for counter saturation and mid-op reset.
module tb_stream_demux;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (default parameters)
  logic        rst, in_valid, in_ready, in_sel;
  logic [31:0] in_data;
  logic        out0_valid, out0_ready, out1_valid, out1_ready;
  logic [31:0] out0_data, out1_data;
  logic [15:0] cnt0, cnt1;

  // Saturation instance (CNT_WIDTH=4)
  logic        s_rst, s_in_valid, s_in_ready, s_in_sel;
  logic [31:0] s_in_data;
  logic        s_out0_valid, s_out0_ready, s_out1_valid, s_out1_ready;
  logic [31:0] s_out0_data, s_out1_data;
  logic [3:0]  s_cnt0, s_cnt1;

  int n_cmp = 0;
  int n_err = 0;
  int accepts;

  stream_demux #(.WIDTH(32), .CNT_WIDTH(16)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
    .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_data(out0_data),
    .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  stream_demux #(.WIDTH(32), .CNT_WIDTH(4)) u_sat (
    .clk(clk), .rst(s_rst),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data), .in_sel(s_in_sel),
    .out0_valid(s_out0_valid), .out0_ready(s_out0_ready), .out0_data(s_out0_data),
    .out1_valid(s_out1_valid), .out1_ready(s_out1_ready), .out1_data(s_out1_data),
    .cnt0(s_cnt0), .cnt1(s_cnt1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset with input valid held high: nothing may be captured
    rst = 1'b1; in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hFFFF_FFFF;
    out0_ready = 1'b1; out1_ready = 1'b1;
    s_rst = 1'b1; s_in_valid = 1'b0; s_in_sel = 1'b1; s_in_data = '0;
    s_out0_ready = 1'b1; s_out1_ready = 1'b1;
    tick(); tick();
    chk("rst_out0_valid", {31'd0, out0_valid}, 32'd0);
    chk("rst_out1_valid", {31'd0, out1_valid}, 32'd0);
    chk("rst_out0_data", out0_data, 32'd0);
    chk("rst_out1_data", out1_data, 32'd0);
    chk("rst_cnt0", {16'd0, cnt0}, 32'd0);
    chk("rst_cnt1", {16'd0, cnt1}, 32'd0);

    // Routing
    rst = 1'b0; in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hDEAD_BEEF;
    #1 chk("route_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_sel = 1'b1; in_data = 32'h1234_5678;
    chk("route_out0_valid", {31'd0, out0_valid}, 32'd1);
    chk("route_out0_data", out0_data, 32'hDEAD_BEEF);
    chk("route_out1_empty", {31'd0, out1_valid}, 32'd0);
    tick();
    in_valid = 1'b0;
    chk("route_out1_valid", {31'd0, out1_valid}, 32'd1);
    chk("route_out1_data", out1_data, 32'h1234_5678);
    chk("route_out0_drained", {31'd0, out0_valid}, 32'd0);
    chk("route_cnt0", {16'd0, cnt0}, 32'd1);
    tick();
    chk("route_cnt1", {16'd0, cnt1}, 32'd1);
    chk("route_out1_drained", {31'd0, out1_valid}, 32'd0);

    // Stall / backpressure on port 0
    out0_ready = 1'b0; in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hAAAA_0001;
    tick();
    in_data = 32'hBBBB_0002;
    #1 chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("stall_hold_data", out0_data, 32'hAAAA_0001);
    chk("stall_hold_valid", {31'd0, out0_valid}, 32'd1);
    chk("stall_cnt0", {16'd0, cnt0}, 32'd1);
    out0_ready = 1'b1;
    #1 chk("unstall_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("unstall_cnt0_a", {16'd0, cnt0}, 32'd2);
    chk("unstall_data_b", out0_data, 32'hBBBB_0002);
    chk("unstall_valid_b", {31'd0, out0_valid}, 32'd1);
    tick();
    chk("unstall_cnt0_b", {16'd0, cnt0}, 32'd3);
    chk("unstall_empty", {31'd0, out0_valid}, 32'd0);

    // Independence: port 0 stalled and full, port 1 still accepts
    out0_ready = 1'b0; in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h0000_C0DE;
    tick();
    out1_ready = 1'b0; in_sel = 1'b1; in_data = 32'hCAFE_0001;
    #1 chk("indep_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("indep_out1_valid", {31'd0, out1_valid}, 32'd1);
    chk("indep_out1_data", out1_data, 32'hCAFE_0001);
    chk("indep_out0_data", out0_data, 32'h0000_C0DE);
    chk("indep_out0_valid", {31'd0, out0_valid}, 32'd1);
    chk("indep_cnt0", {16'd0, cnt0}, 32'd3);
    out0_ready = 1'b1; out1_ready = 1'b1;
    tick();
    chk("indep_drain_cnt0", {16'd0, cnt0}, 32'd4);
    chk("indep_drain_cnt1", {16'd0, cnt1}, 32'd2);

    // Throughput: fresh counters, 100 back-to-back alternating words
    rst = 1'b1;
    tick();
    rst = 1'b0;
    accepts = 0;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1; in_sel = i[0]; in_data = 32'h0000_0100 + i;
      #1;
      if (in_valid && in_ready) accepts++;
      tick();
      if (i[0]) chk("thru_out1_data", out1_data, 32'h0000_0100 + i);
      else      chk("thru_out0_data", out0_data, 32'h0000_0100 + i);
    end
    in_valid = 1'b0;
    tick();
    chk("thru_accepts", accepts, 32'd100);
    chk("thru_cnt0", {16'd0, cnt0}, 32'd50);
    chk("thru_cnt1", {16'd0, cnt1}, 32'd50);

    // Saturation on 4-bit counter, then reset with port 1 full
    s_rst = 1'b0; s_in_valid = 1'b1; s_in_sel = 1'b1; s_out1_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s_in_data = 32'h5A00_0000 + i;
      tick();
      if (i == 15) chk("sat_cnt1_at_15", {28'd0, s_cnt1}, 32'd15);
    end
    s_in_valid = 1'b0; s_out1_ready = 1'b0;
    #1;
    chk("sat_cnt1", {28'd0, s_cnt1}, 32'd15);
    chk("sat_out1_full", {31'd0, s_out1_valid}, 32'd1);
    chk("sat_out1_data", s_out1_data, 32'h5A00_0013);
    tick();
    s_rst = 1'b1;
    tick();
    s_rst = 1'b0;
    chk("sat_rst_valid", {31'd0, s_out1_valid}, 32'd0);
    chk("sat_rst_cnt1", {28'd0, s_cnt1}, 32'd0);
    chk("sat_rst_data", s_out1_data, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
